input_current_accumulator: RTL and testbench



---
 rtl/input_current_accumulator_if.sv | 23 ++
 rtl/input_current_accumulator.sv | 116 +++++++++++
 tb/tb_input_current_accumulator.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_current_accumulator_if.sv
// Operand/result bundle between the spike/weight register file and the accumulator.
interface input_current_accumulator_if #(
  parameter int M     = 8,
  parameter int W     = 2,
  parameter int OUT_W = 6
);
  logic                    start;
  logic [M-1:0]            input_spikes;
  logic [M*W-1:0]          weights;
  logic signed [OUT_W-1:0] input_current;
  logic                    busy;
  logic                    done;

  modport master (
    output start, input_spikes, weights,
    input  input_current, busy, done
  );

  modport slave (
    input  start, input_spikes, weights,
    output input_current, busy, done
  );
endinterface

// File: rtl/input_current_accumulator.sv
// Time-multiplexed weighted-spike accumulator, LANES inputs per cycle; done N+1 cycles after start.
// start is ignored while busy (no queuing); ICC_SATURATE_EN clamps each step instead of wrapping.
module input_current_accumulator #(
  parameter int M     = 8,
  parameter int W     = 2,
  parameter int LANES = 4,
  parameter int OUT_W = 6
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input_current_accumulator_if.slave    io_bus
);
  localparam int N    = (M + LANES - 1) / LANES;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int SW   = W + $clog2(LANES) + 1;
  localparam int AW   = OUT_W + 1;
  localparam int SUMW = ((AW > SW) ? AW : SW) + 1;
  localparam int PADN = N * LANES;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  r_state;
  logic [M-1:0]            r_spikes;
  logic [M*W-1:0]          r_weights;
  logic [CW-1:0]           r_chunk;
  logic signed [AW-1:0]    r_acc;
  logic signed [OUT_W-1:0] r_current;
  logic                    r_busy;
  logic                    r_done;

  logic [PADN-1:0]         w_spk_pad;
  logic [PADN*W-1:0]       w_wt_pad;
  logic signed [W-1:0]     w_lane_wt;
  logic signed [SW-1:0]    w_chunk_sum;
  logic signed [SUMW-1:0]  w_sum;
  logic signed [AW-1:0]    w_acc_next;

  // Zero padding past M makes the tail lanes of the last chunk contribute nothing.
  always_comb begin
    w_spk_pad = '0;
    w_wt_pad  = '0;
    w_spk_pad[M-1:0]   = r_spikes;
    w_wt_pad[M*W-1:0]  = r_weights;
  end

  always_comb begin
    w_chunk_sum = '0;
    w_lane_wt   = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_wt = w_wt_pad[(int'(r_chunk) * LANES + l) * W +: W];
      if (w_spk_pad[int'(r_chunk) * LANES + l])
        w_chunk_sum = w_chunk_sum + SW'(w_lane_wt);
    end
  end

  assign w_sum = SUMW'(r_acc) + SUMW'(w_chunk_sum);

`ifdef ICC_SATURATE_EN
  localparam logic signed [SUMW-1:0] MAXV = SUMW'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [SUMW-1:0] MINV = SUMW'(-(1 <<< (OUT_W - 1)));

  always_comb begin
    if (w_sum > MAXV)
      w_acc_next = AW'(MAXV);
    else if (w_sum < MINV)
      w_acc_next = AW'(MINV);
    else
      w_acc_next = AW'(w_sum);
  end
`else
  logic signed [OUT_W-1:0] w_wrap;

  always_comb begin
    w_wrap     = OUT_W'(w_sum);
    w_acc_next = AW'(w_wrap);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_spikes  <= '0;
      r_weights <= '0;
      r_chunk   <= '0;
      r_acc     <= '0;
      r_current <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (io_bus.start) begin
          r_spikes  <= io_bus.input_spikes;
          r_weights <= io_bus.weights;
          r_acc     <= '0;
          r_chunk   <= '0;
          r_busy    <= 1'b1;
          r_state   <= ACCUM;
        end
      end else begin
        r_acc   <= w_acc_next;
        r_chunk <= r_chunk + 1'b1;
        if (r_chunk == CW'(N - 1)) begin
          r_current <= w_acc_next[OUT_W-1:0];
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      end
    end
  end

  assign io_bus.input_current = r_current;
  assign io_bus.busy          = r_busy;
  assign io_bus.done          = r_done;
endmodule

// File: tb/tb_input_current_accumulator.sv
// Bench for input_current_accumulator across four parameter sets, checked against a chunk-level arithmetic model.
module tb_input_current_accumulator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  start_g;
  logic [15:0] spk_g;
  logic [31:0] wts_g;
  logic [3:0]  done_g;
  logic [3:0]  busy_g;
  int          cur_g [4];

  int checks = 0;
  int errors = 0;

  input_current_accumulator_if #(.M(8),  .W(2), .OUT_W(6)) if0 ();
  input_current_accumulator_if #(.M(6),  .W(2), .OUT_W(6)) if1 ();
  input_current_accumulator_if #(.M(16), .W(2), .OUT_W(5)) if2 ();
  input_current_accumulator_if #(.M(4),  .W(2), .OUT_W(6)) if3 ();

  input_current_accumulator #(.M(8),  .W(2), .LANES(4), .OUT_W(6)) u0 (.i_clk(clk), .i_reset(reset), .io_bus(if0));
  input_current_accumulator #(.M(6),  .W(2), .LANES(4), .OUT_W(6)) u1 (.i_clk(clk), .i_reset(reset), .io_bus(if1));
  input_current_accumulator #(.M(16), .W(2), .LANES(4), .OUT_W(5)) u2 (.i_clk(clk), .i_reset(reset), .io_bus(if2));
  input_current_accumulator #(.M(4),  .W(2), .LANES(4), .OUT_W(6)) u3 (.i_clk(clk), .i_reset(reset), .io_bus(if3));

  assign if0.start = start_g[0];
  assign if0.input_spikes = spk_g[7:0];
  assign if0.weights = wts_g[15:0];
  assign if1.start = start_g[1];
  assign if1.input_spikes = spk_g[5:0];
  assign if1.weights = wts_g[11:0];
  assign if2.start = start_g[2];
  assign if2.input_spikes = spk_g[15:0];
  assign if2.weights = wts_g[31:0];
  assign if3.start = start_g[3];
  assign if3.input_spikes = spk_g[3:0];
  assign if3.weights = wts_g[7:0];

  assign done_g[0] = if0.done;
  assign done_g[1] = if1.done;
  assign done_g[2] = if2.done;
  assign done_g[3] = if3.done;
  assign busy_g[0] = if0.busy;
  assign busy_g[1] = if1.busy;
  assign busy_g[2] = if2.busy;
  assign busy_g[3] = if3.busy;
  assign cur_g[0] = int'(if0.input_current);
  assign cur_g[1] = int'(if1.input_current);
  assign cur_g[2] = int'(if2.input_current);
  assign cur_g[3] = int'(if3.input_current);

  function automatic int cfg_m(input int d);
    case (d)
      0: return 8;
      1: return 6;
      2: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_ow(input int d);
    return (d == 2) ? 5 : 6;
  endfunction

  // Reference: 2-bit signed weights, 4 inputs per step, result range-limited after every step.
  function automatic int model(input int m, input int ow, input logic [15:0] spk, input logic [31:0] wts);
    int acc, s, v, i, hi, lo, span;
    acc  = 0;
    hi   = (1 << (ow - 1)) - 1;
    lo   = -(1 << (ow - 1));
    span = 1 << ow;
    for (int c = 0; c * 4 < m; c++) begin
      s = 0;
      for (int l = 0; l < 4; l++) begin
        i = c * 4 + l;
        if (i < m && spk[i]) begin
          v = int'((wts >> (2 * i)) & 32'd3);
          if (v > 1) v = v - 4;
          s = s + v;
        end
      end
      acc = acc + s;
`ifdef ICC_SATURATE_EN
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
`else
      acc = ((acc % span) + span) % span;
      if (acc > hi) acc = acc - span;
`endif
    end
    return acc;
  endfunction

  task automatic run_op(input int d, input logic [15:0] spk, input logic [31:0] wts, input int exp,
                        input bit b2b, input bit poke, input bit tail, input string nm);
    int n, waited, nbusy;
    n = (cfg_m(d) + 3) / 4;
    if (!b2b) @(negedge clk);
    spk_g = spk;
    wts_g = wts;
    start_g = '0;
    start_g[d] = 1'b1;
    waited = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      waited++;
      if (waited == 1) begin
        start_g = '0;
        spk_g = 16'($urandom);
        wts_g = $urandom;
        if (poke) start_g[d] = 1'b1;
      end else if (waited == 2) begin
        start_g = '0;
      end
      if (!done_g[d] && busy_g[d]) nbusy++;
    end while (!done_g[d] && waited < 40);

    checks++;
    if (waited !== n + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", nm, waited, n + 1);
    end
    checks++;
    if (nbusy !== n) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", nm, nbusy, n);
    end
    checks++;
    if (cur_g[d] !== exp) begin
      errors++;
      $display("FAIL %s input_current: got %0d, expected %0d", nm, cur_g[d], exp);
    end
    checks++;
    if (busy_g[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, expected 0", nm, busy_g[d]);
    end
    if (tail) begin
      @(negedge clk);
      checks++;
      if (done_g[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s done_single: got %b, expected 0", nm, done_g[d]);
      end
      checks++;
      if (cur_g[d] !== exp) begin
        errors++;
        $display("FAIL %s hold: got %0d, expected %0d", nm, cur_g[d], exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_g = '0;
    spk_g = '0;
    wts_g = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (busy_g[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy[%0d]: got %b, expected 0", d, busy_g[d]);
      end
      checks++;
      if (done_g[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_done[%0d]: got %b, expected 0", d, done_g[d]);
      end
      checks++;
      if (cur_g[d] !== 0) begin
        errors++;
        $display("FAIL reset_current[%0d]: got %0d, expected 0", d, cur_g[d]);
      end
    end
  endtask

  task automatic test_basic();
    run_op(0, 16'h00FF, 32'h5555, 8,   1'b0, 1'b0, 1'b1, "all_plus1");
    run_op(0, 16'h00FF, 32'hAAAA, -16, 1'b0, 1'b0, 1'b1, "all_minus2");
    run_op(0, 16'h000F, 32'hFFFF, -4,  1'b0, 1'b0, 1'b1, "half_minus1");
    run_op(0, 16'h0000, 32'hFFFF, 0,   1'b0, 1'b0, 1'b1, "no_spikes");
  endtask

  task automatic test_padding();
    run_op(1, 16'h003F, 32'h0555, 6, 1'b0, 1'b0, 1'b1, "pad_m6");
  endtask

  task automatic test_overflow();
`ifdef ICC_SATURATE_EN
    run_op(2, 16'hFFFF, 32'hAAAAAAAA, -16, 1'b0, 1'b0, 1'b1, "ovf_m16");
`else
    run_op(2, 16'hFFFF, 32'hAAAAAAAA, 0,   1'b0, 1'b0, 1'b1, "ovf_m16");
`endif
  endtask

  task automatic test_single_chunk();
    run_op(3, 16'h000F, 32'h0055, 4, 1'b0, 1'b0, 1'b1, "single_chunk");
  endtask

  task automatic test_busy_ignore();
    run_op(0, 16'h00FF, 32'h5555, 8, 1'b0, 1'b1, 1'b1, "busy_ignore");
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    spk_g = 16'h00FF;
    wts_g = 32'hAAAA;
    start_g = 4'b0001;
    @(negedge clk);
    start_g = '0;
    checks++;
    if (busy_g[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b, expected 1", busy_g[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy_g[0] !== 1'b0 || done_g[0] !== 1'b0 || cur_g[0] !== 0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b cur=%0d, expected 0 0 0", busy_g[0], done_g[0], cur_g[0]);
    end
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_g[0]) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL mid_no_done: got %0d done pulses, expected 0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    run_op(0, 16'h00FF, 32'h5555, 8,  1'b0, 1'b0, 1'b0, "b2b_first");
    run_op(0, 16'h000F, 32'hFFFF, -4, 1'b1, 1'b0, 1'b1, "b2b_second");
  endtask

  task automatic test_random();
    int d, exp;
    logic [15:0] spk;
    logic [31:0] wts;
    for (int k = 0; k < 24; k++) begin
      d = int'($urandom_range(0, 3));
      spk = 16'($urandom);
      wts = $urandom;
      exp = model(cfg_m(d), cfg_ow(d), spk, wts);
      run_op(d, spk, wts, exp, 1'b0, 1'b0, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_overflow();
    test_single_chunk();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
